// File: rtl/lcd_ejecutor.sv
// Responder side of the LCD control handshake: decodes the controller state bits,
// runs power-up wait, init ROM, character writes with line wrap, and drives an 8-bit HD44780 bus.
module lcd_ejecutor #(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 12,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned EXEC_CYC    = 2500,
    parameter int unsigned CLEAR_CYC   = 82000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Comenzar,
    input  logic       Mostrar,
    input  logic       Ejecutar,
    input  logic [7:0] Char,
    output logic       Init,
    output logic       InitEscrito,
    output logic       DoneInit,
    output logic       CharEscrito,
    output logic       WrittenLCD,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB,
    output logic [4:0] Cursor
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } eng_t;

    localparam logic [2:0] ENC_POWERUP  = 3'b100;
    localparam logic [2:0] ENC_WRITE    = 3'b001;
    localparam logic [2:0] ENC_INITCHK  = 3'b101;
    localparam logic [2:0] ENC_MAINIDLE = 3'b010;

    localparam logic [19:0] PWR_LIM = 20'(POWERUP_CYC - 1);
    localparam logic [19:0] SET_LIM = 20'(SETUP_CYC - 1);
    localparam logic [19:0] PUL_LIM = 20'(PULSE_CYC - 1);
    localparam logic [19:0] HLD_LIM = 20'(HOLD_CYC - 1);
    localparam logic [19:0] EXE_LIM = 20'(EXEC_CYC - 1);
    localparam logic [19:0] CLR_LIM = 20'(CLEAR_CYC - 1);

    function automatic logic [7:0] init_rom(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    eng_t        state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic [19:0] pwr_cnt;
    logic [19:0] exec_lim;
    logic [2:0]  enc;
    logic [1:0]  idx;
    logic        armed;
    logic        wrap_pend;
    logic        start;
    logic        hold_done;
    logic        exec_done;
    logic        wrap_go;

    assign enc    = {Comenzar, Mostrar, Ejecutar};
    assign LCD_RW = 1'b0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        hold_done = 1'b0;
        exec_done = 1'b0;
        wrap_go   = 1'b0;
        exec_lim  = (LCD_DB == 8'h01) ? CLR_LIM : EXE_LIM;
        case (state)
            ST_IDLE: begin
                if (enc == ENC_WRITE && armed) begin
                    start     = 1'b1;
                    state_nxt = ST_SETUP;
                    cnt_nxt   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt == SET_LIM) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            ST_PULSE: begin
                if (cnt == PUL_LIM) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == HLD_LIM) begin
                    hold_done = 1'b1;
                    state_nxt = ST_EXEC;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            ST_EXEC: begin
                if (cnt == exec_lim) begin
                    exec_done = 1'b1;
                    cnt_nxt   = '0;
                    // A data byte landing in the last column of a line chains a cursor command
                    wrap_go   = DoneInit && !wrap_pend &&
                                (Cursor == 5'd15 || Cursor == 5'd31);
                    state_nxt = wrap_go ? ST_SETUP : ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pwr_cnt     <= '0;
            idx         <= '0;
            armed       <= 1'b1;
            wrap_pend   <= 1'b0;
            Init        <= 1'b0;
            InitEscrito <= 1'b0;
            DoneInit    <= 1'b0;
            CharEscrito <= 1'b0;
            WrittenLCD  <= 1'b0;
            LCD_RS      <= 1'b0;
            LCD_E       <= 1'b0;
            LCD_DB      <= '0;
            Cursor      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            LCD_E <= (state_nxt == ST_PULSE);

            if (enc == ENC_POWERUP && !Init) begin
                if (pwr_cnt == PWR_LIM) begin
                    Init <= 1'b1;
                end else begin
                    pwr_cnt <= pwr_cnt + 20'd1;
                end
            end

            // Re-arming only from 101/010 blocks the controller's trailing 001 from re-writing
            if (start) begin
                armed <= 1'b0;
            end else if (enc == ENC_INITCHK || enc == ENC_MAINIDLE) begin
                armed <= 1'b1;
            end

            if (start) begin
                InitEscrito <= 1'b0;
                CharEscrito <= 1'b0;
                WrittenLCD  <= 1'b0;
                if (!DoneInit) begin
                    LCD_RS <= 1'b0;
                    LCD_DB <= init_rom(idx);
                end else begin
                    LCD_RS <= 1'b1;
                    LCD_DB <= Char;
                end
            end

            if (hold_done) begin
                if (DoneInit) begin
                    CharEscrito <= 1'b1;
                end else begin
                    InitEscrito <= 1'b1;
                end
            end

            if (exec_done) begin
                if (!DoneInit) begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        DoneInit <= 1'b1;
                    end
                end else if (wrap_pend) begin
                    wrap_pend  <= 1'b0;
                    WrittenLCD <= 1'b1;
                end else begin
                    Cursor <= Cursor + 5'd1;
                    if (wrap_go) begin
                        wrap_pend <= 1'b1;
                        LCD_RS    <= 1'b0;
                        LCD_DB    <= (Cursor == 5'd15) ? 8'hC0 : 8'h80;
                    end else begin
                        WrittenLCD <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/lcd_ejecutor.md
Name: lcd_ejecutor

Overview:
- Responder end of the LCD control handshake: decodes the controller's Comenzar/Mostrar/Ejecutar state encoding and drives an HD44780-style 8-bit LCD bus.
- Generates the completion flags the controller waits on: Init, InitEscrito, DoneInit, CharEscrito, WrittenLCD.
- Runs the power-up wait, the 4-command init ROM, character writes, and automatic line wrap.

Parameters:
POWERUP_CYC  750000  cycles waited before Init rises (15 ms @ 50 MHz)
SETUP_CYC  2  RS/DB setup cycles before E rises
PULSE_CYC  12  E high time in cycles
HOLD_CYC  2  DB/RS hold cycles after E falls
EXEC_CYC  2500  post-write execution wait, normal commands/data
CLEAR_CYC  82000  post-write execution wait for clear (0x01)

Ports:
Clk  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Comenzar  in  1  controller state bit
Mostrar  in  1  controller state bit
Ejecutar  in  1  controller state bit
Char  in  8  ASCII character to write, sampled at write start
Init  out  1  power-up wait complete (level)
InitEscrito  out  1  init command transferred (level)
DoneInit  out  1  all init commands executed (level)
CharEscrito  out  1  character transferred (level)
WrittenLCD  out  1  character (plus any wrap command) executed (level)
LCD_RS  out  1  register select: 0 = command, 1 = data
LCD_RW  out  1  tied 0 (write only)
LCD_E  out  1  enable strobe
LCD_DB  out  8  data bus
Cursor  out  5  current DDRAM position, 0..31

Behaviour:
- Reset value of every output and counter is 0; engine enters IDLE; LCD_E is low on the first edge after Reset.
- Reset mid-write aborts the write with no completion flag.
- Input decode {Comenzar,Mostrar,Ejecutar}:
  - 100 = power-up request
  - 001 = write request
  - 101 = init check
  - 010 = main idle
  - 011 = main check
  - 000 = idle
- Power-up: while 100 and Init=0, a counter increments each cycle. When it reaches POWERUP_CYC-1, Init=1 and stays 1 until Reset. The counter holds its value when the encoding leaves 100.
- Armed flag:
  - Set by Reset release and on any cycle with encoding 101 or 010.
  - Cleared when a write starts.
  - A write starts only when encoding is 001, armed=1 and engine is IDLE; otherwise 001 is ignored.
  - This keeps the controller's trailing 001 state after a completed character from triggering a duplicate write.
- Write source:
  - If DoneInit=0: RS=0, DB=ROM[idx] with ROM = 0x38, 0x0C, 0x01, 0x06.
  - Else: RS=1, DB=Char, latched at start.
- Engine states:
  - IDLE -> SETUP: write start; clears InitEscrito, CharEscrito, WrittenLCD.
  - SETUP: E=0 for SETUP_CYC cycles.
  - PULSE: E=1 for PULSE_CYC cycles.
  - HOLD: E=0, RS/DB held, for HOLD_CYC cycles. On exit, set InitEscrito (init phase) or CharEscrito (main phase).
  - EXEC: wait CLEAR_CYC if DB=0x01, else EXEC_CYC.
  - EXEC -> IDLE. Init phase: idx increments, and DoneInit=1 when idx reaches 4. Main phase: Cursor increments, then WrittenLCD=1 unless a wrap is pending.
- Line wrap (main phase only):
  - After the data write at Cursor 15, engine issues command 0xC0 (SETUP..EXEC) before setting WrittenLCD.
  - After Cursor 31, engine issues command 0x80 and Cursor wraps to 0.
  - CharEscrito is already 1 during the wrap command.
- Completion flags are levels held until the next write start or Reset. DoneInit is sticky.
- RS and DB are stable from SETUP entry through HOLD exit.
- LCD_RW is always 0.
- Exactly one E pulse per command/data byte.
- Cycle counters are 20 bits wide; parameters must be ≥1 and < 2^20.
- If 101 arrives while EXEC is still running, armed is set; the next 001 write starts as soon as the engine reaches IDLE.

Test Plan (all parameters set to 2 except POWERUP_CYC=10, CLEAR_CYC=20):
- Reset, hold 100 for 12 cycles -> Init rises on the 10th cycle of 100; all other outputs stay 0.
- Full init: loop 001 until InitEscrito, then 101 -> LCD_DB sequence 0x38, 0x0C, 0x01, 0x06, RS=0, four E pulses each 2 cycles high. The 0x01 EXEC lasts 20 cycles. DoneInit=1 only after the 4th EXEC.
- Main write: 010, Char=0x41, 001 until CharEscrito, then 011 -> one E pulse with RS=1, DB=0x41. WrittenLCD=1 after EXEC; Cursor=1.
- Duplicate guard: after WrittenLCD, drive 001 for 5 cycles with no preceding 010/101 -> no E pulse, flags unchanged.
- Wrap: write 16 characters -> after the 16th data pulse, a 0xC0 RS=0 pulse precedes WrittenLCD, Cursor=16. After 32 characters, a 0x80 pulse is issued and Cursor=0.
- Reset asserted during PULSE of a data write -> LCD_E=0 on the next edge, all flags 0. Init must be re-earned via 100.
